// File: rtl/mag_scan_pkg.sv
// Shared types and defaults for the magnitude scan sequencer.
// State encoding, width helpers and the default index shift.
package mag_scan_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int DATA_W_DEF    = 16;
  localparam int MAG_W_DEF     = 16;
  localparam int N_BINS_DEF    = 256;
  localparam int LUT_DEPTH_DEF = 256;
  localparam int LUT_LOG_DEF   = $clog2(LUT_DEPTH_DEF);
  localparam int ADDR_W_DEF    = $clog2(N_BINS_DEF);
  localparam int SHIFT_DEF     = 7;

  // A single-entry table still needs a 1-bit address.
  function automatic int addr_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mag_lut_index.sv
// Signed sample to saturated LUT index: min(|x| >> SHIFT, LUT_DEPTH-1).
// Magnitude is formed one bit wider so the most negative input stays positive.
module mag_lut_index
  import mag_scan_pkg::*;
#(
  parameter  int DATA_WIDTH = DATA_W_DEF,
  parameter  int LUT_DEPTH  = LUT_DEPTH_DEF,
  parameter  int SHIFT      = SHIFT_DEF,
  localparam int LUT_LOG    = $clog2(LUT_DEPTH)
) (
  input  logic signed [DATA_WIDTH-1:0] i_sample,
  output logic        [LUT_LOG-1:0]    o_idx
);

  localparam logic [DATA_WIDTH:0] MAX_IDX =
    (DATA_WIDTH+1)'(LUT_DEPTH - 1);

  logic [DATA_WIDTH:0] w_ext;
  logic [DATA_WIDTH:0] w_abs;
  logic [DATA_WIDTH:0] w_shr;

  assign w_ext = {i_sample[DATA_WIDTH-1], i_sample};
  assign w_abs = i_sample[DATA_WIDTH-1] ? -w_ext : w_ext;
  assign w_shr = w_abs >> SHIFT;

  assign o_idx = (w_shr > MAX_IDX) ? LUT_LOG'(MAX_IDX)
                                   : w_shr[LUT_LOG-1:0];

endmodule

// File: rtl/mag_scan_ctrl.sv
// Sweeps FFT bins, drives the magnitude LUT and writes the spectrum RAM.
// Define MAG_SCAN_PEAK_EN to build the running peak tracker.
module mag_scan_ctrl
  import mag_scan_pkg::*;
#(
  parameter  int DATA_WIDTH = DATA_W_DEF,
  parameter  int MAG_WIDTH  = MAG_W_DEF,
  parameter  int N_BINS     = N_BINS_DEF,
  parameter  int LUT_DEPTH  = LUT_DEPTH_DEF,
  parameter  int SHIFT      = SHIFT_DEF,
  localparam int LUT_LOG    = $clog2(LUT_DEPTH),
  localparam int AW         = addr_width(N_BINS)
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_start,
  input  logic                         i_abort,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_bin_rd,
  output logic        [AW-1:0]         o_bin_addr,
  input  logic signed [DATA_WIDTH-1:0] i_bin_real,
  input  logic signed [DATA_WIDTH-1:0] i_bin_imag,
  output logic                         o_mag_en,
  output logic        [LUT_LOG-1:0]    o_mag_addr_real,
  output logic        [LUT_LOG-1:0]    o_mag_addr_cplx,
  input  logic        [MAG_WIDTH-1:0]  i_mag_in,
  output logic                         o_out_we,
  output logic        [AW-1:0]         o_out_addr,
  output logic        [MAG_WIDTH-1:0]  o_out_data,
  output logic        [MAG_WIDTH-1:0]  o_peak_mag,
  output logic        [AW-1:0]         o_peak_bin
);

  state_t r_state;
  state_t w_next;

  logic [AW-1:0]      r_rd_cnt;
  logic [AW-1:0]      r_addr1;
  logic [AW-1:0]      r_addr2;
  logic               r_v1;
  logic               r_v2;
  logic               w_last;
  logic               w_accept;
  logic               w_run;
  logic [LUT_LOG-1:0] w_idx_re;
  logic [LUT_LOG-1:0] w_idx_im;

  assign w_run    = (r_state == S_RUN);
  assign w_last   = (r_rd_cnt == AW'(N_BINS - 1));
  assign w_accept = (r_state == S_IDLE) && i_start && !i_abort;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (i_abort) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (i_start) w_next = S_RUN;
        S_RUN:   if (w_last) w_next = S_DRAIN;
        // v2 takes v1 at this edge, so an empty v1 empties both
        S_DRAIN: if (!r_v1) w_next = S_DONE;
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rd_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_rd_cnt <= '0;
    end else if (w_run) begin
      r_rd_cnt <= r_rd_cnt + AW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_addr1 <= '0;
      r_addr2 <= '0;
    end else begin
      r_v1 <= w_run && !i_abort;
      r_v2 <= r_v1 && !i_abort;
      if (w_run) r_addr1 <= r_rd_cnt;
      if (r_v1) r_addr2 <= r_addr1;
    end
  end

  mag_lut_index #(
    .DATA_WIDTH (DATA_WIDTH),
    .LUT_DEPTH  (LUT_DEPTH),
    .SHIFT      (SHIFT)
  ) u_idx_re (
    .i_sample (i_bin_real),
    .o_idx    (w_idx_re)
  );

  mag_lut_index #(
    .DATA_WIDTH (DATA_WIDTH),
    .LUT_DEPTH  (LUT_DEPTH),
    .SHIFT      (SHIFT)
  ) u_idx_im (
    .i_sample (i_bin_imag),
    .o_idx    (w_idx_im)
  );

  assign o_busy          = w_run || (r_state == S_DRAIN);
  assign o_done          = (r_state == S_DONE);
  assign o_bin_rd        = w_run;
  assign o_bin_addr      = r_rd_cnt;
  assign o_mag_en        = r_v1;
  assign o_mag_addr_real = r_v1 ? w_idx_re : '0;
  assign o_mag_addr_cplx = r_v1 ? w_idx_im : '0;
  assign o_out_we        = r_v2;
  assign o_out_addr      = r_addr2;
  assign o_out_data      = r_v2 ? i_mag_in : '0;

`ifdef MAG_SCAN_PEAK_EN
  logic [MAG_WIDTH-1:0] r_peak_mag;
  logic [AW-1:0]        r_peak_bin;

  // Strict compare keeps the lowest bin on ties.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_peak_mag <= '0;
      r_peak_bin <= '0;
    end else if (w_accept) begin
      r_peak_mag <= '0;
      r_peak_bin <= '0;
    end else if (r_v2 && (i_mag_in > r_peak_mag)) begin
      r_peak_mag <= i_mag_in;
      r_peak_bin <= r_addr2;
    end
  end

  assign o_peak_mag = r_peak_mag;
  assign o_peak_bin = r_peak_bin;
`else
  assign o_peak_mag = '0;
  assign o_peak_bin = '0;
`endif

endmodule

// File: tb/tb_mag_scan_ctrl.sv
// Scoreboard bench for mag_scan_ctrl with an 8-bin sweep.
// Honours MAG_SCAN_PEAK_EN for the peak expectations.
module tb_mag_scan_ctrl;

  localparam int NB = 8;
  localparam int AW = 3;

`ifdef MAG_SCAN_PEAK_EN
  localparam bit PK = 1'b1;
`else
  localparam bit PK = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               abort;
  logic               o_busy;
  logic               o_done;
  logic               o_bin_rd;
  logic [AW-1:0]      o_bin_addr;
  logic signed [15:0] bin_real = '0;
  logic signed [15:0] bin_imag = '0;
  logic               o_mag_en;
  logic [7:0]         o_mag_addr_real;
  logic [7:0]         o_mag_addr_cplx;
  logic [15:0]        mag_in = '0;
  logic               o_out_we;
  logic [AW-1:0]      o_out_addr;
  logic [15:0]        o_out_data;
  logic [15:0]        o_peak_mag;
  logic [AW-1:0]      o_peak_bin;

  mag_scan_ctrl #(.N_BINS(NB)) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_start         (start),
    .i_abort         (abort),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_bin_rd        (o_bin_rd),
    .o_bin_addr      (o_bin_addr),
    .i_bin_real      (bin_real),
    .i_bin_imag      (bin_imag),
    .o_mag_en        (o_mag_en),
    .o_mag_addr_real (o_mag_addr_real),
    .o_mag_addr_cplx (o_mag_addr_cplx),
    .i_mag_in        (mag_in),
    .o_out_we        (o_out_we),
    .o_out_addr      (o_out_addr),
    .o_out_data      (o_out_data),
    .o_peak_mag      (o_peak_mag),
    .o_peak_bin      (o_peak_bin)
  );

  always #5 clk = ~clk;

  int cnt = 0;
  always @(posedge clk) cnt <= cnt + 1;

  logic signed [15:0] ram_r [NB];
  logic signed [15:0] ram_i [NB];
  logic [15:0]        lutr  [256];
  logic [15:0]        lutc  [256];

  // FFT RAM and LUT unit: one-cycle read latency each
  always @(posedge clk) begin
    if (o_bin_rd) begin
      bin_real <= ram_r[o_bin_addr];
      bin_imag <= ram_i[o_bin_addr];
    end
    if (o_mag_en)
      mag_in <= lutr[o_mag_addr_real] + lutc[o_mag_addr_cplx];
  end

  typedef struct {
    int cyc;
    int a;
    int b;
    int c;
  } ev_t;

  ev_t q_rd[$];
  ev_t q_ix[$];
  ev_t q_wr[$];
  ev_t q_dn[$];

  int total = 0;
  int bad   = 0;

  int exp_ri [NB];
  int exp_ci [NB];
  int exp_d  [NB];

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cnt %0d)",
               nm, act, exp, cnt);
    end
  endtask

  // Monitor: pop one expectation per DUT event
  always @(negedge clk) begin
    ev_t e;
    if (o_bin_rd) begin
      chk("rd_queue", longint'(q_rd.size() > 0), 1);
      if (q_rd.size() > 0) begin
        e = q_rd.pop_front();
        chk("rd_cyc", cnt, e.cyc);
        chk("rd_addr", o_bin_addr, e.a);
      end
    end
    if (o_mag_en) begin
      chk("ix_queue", longint'(q_ix.size() > 0), 1);
      if (q_ix.size() > 0) begin
        e = q_ix.pop_front();
        chk("ix_cyc", cnt, e.cyc);
        chk("ix_real", o_mag_addr_real, e.a);
        chk("ix_cplx", o_mag_addr_cplx, e.b);
      end
    end
    if (o_out_we) begin
      chk("wr_queue", longint'(q_wr.size() > 0), 1);
      if (q_wr.size() > 0) begin
        e = q_wr.pop_front();
        chk("wr_cyc", cnt, e.cyc);
        chk("wr_addr", o_out_addr, e.a);
        chk("wr_data", o_out_data, e.b);
      end
    end
    if (o_done) begin
      chk("done_queue", longint'(q_dn.size() > 0), 1);
      chk("done_busy", o_busy, 0);
      if (q_dn.size() > 0) begin
        e = q_dn.pop_front();
        chk("done_cyc", cnt, e.cyc);
      end
    end
  end

  task automatic load_main();
    int d [NB] = '{5, 9, 9, 3, 1, 2, 0, 4};
    for (int k = 0; k < NB; k++) begin
      ram_r[k]  = 16'(k * 128);
      ram_i[k]  = '0;
      exp_ri[k] = k;
      exp_ci[k] = 0;
      exp_d[k]  = d[k];
    end
  endtask

  task automatic load_sat();
    int r  [NB] = '{-32768, 32767, -129, 0, 256, -1, 16383, 32640};
    int im [NB] = '{127, -129, -32768, 0, -256, 1, -16384, -32640};
    int ri [NB] = '{255, 255, 1, 0, 2, 0, 127, 255};
    int ci [NB] = '{0, 1, 255, 0, 2, 0, 128, 255};
    int d  [NB] = '{355, 357, 519, 5, 13, 5, 483, 865};
    for (int k = 0; k < NB; k++) begin
      ram_r[k]  = 16'(r[k]);
      ram_i[k]  = 16'(im[k]);
      exp_ri[k] = ri[k];
      exp_ci[k] = ci[k];
      exp_d[k]  = d[k];
    end
  endtask

  task automatic push(input int ts, input int nrd, input int nix,
                      input int nwr, input bit dn);
    for (int k = 0; k < nrd; k++)
      q_rd.push_back('{ts + k, k, 0, 0});
    for (int k = 0; k < nix; k++)
      q_ix.push_back('{ts + 1 + k, exp_ri[k], exp_ci[k], 0});
    for (int k = 0; k < nwr; k++)
      q_wr.push_back('{ts + 2 + k, k, exp_d[k], 0});
    if (dn)
      q_dn.push_back('{ts + NB + 2, 0, 0, 0});
  endtask

  // mode 0: full frame, 1: abort, 2: reset mid-frame
  task automatic run_frame(input int mode, input int pm,
                           input int pb, input bit clr);
    int ts;
    @(negedge clk);
    start = 1'b1;
    ts = cnt + 1;
    if (mode == 0) push(ts, NB, NB, NB, 1'b1);
    else           push(ts, 5, 4, 3, 1'b0);
    @(negedge clk);
    start = 1'b0;
    chk("busy_run", o_busy, 1);
    if (clr) begin
      chk("peak_clr_mag", o_peak_mag, 0);
      chk("peak_clr_bin", o_peak_bin, 0);
    end
    if (mode == 0) begin
      while (cnt < ts + NB + 3) begin
        start = (cnt == ts + 3);
        @(negedge clk);
      end
      start = 1'b0;
      chk("busy_after", o_busy, 0);
      chk("peak_mag", o_peak_mag, PK ? pm : 0);
      chk("peak_bin", o_peak_bin, PK ? pb : 0);
    end else if (mode == 1) begin
      while (cnt < ts + 4) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", o_busy, 0);
      chk("abort_we", o_out_we, 0);
      repeat (6) @(negedge clk);
    end else begin
      while (cnt < ts + 4) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("rst_busy", o_busy, 0);
      chk("rst_rd", o_bin_rd, 0);
      chk("rst_addr", o_bin_addr, 0);
      chk("rst_mag_en", o_mag_en, 0);
      chk("rst_we", o_out_we, 0);
      chk("rst_out_addr", o_out_addr, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 256; i++) begin
      lutr[i] = 16'(i + 100);
      lutc[i] = 16'(2 * i);
    end
    lutr[0] = 16'd5; lutr[1] = 16'd9;
    lutr[2] = 16'd9; lutr[3] = 16'd3;
    lutr[4] = 16'd1; lutr[5] = 16'd2;
    lutr[6] = 16'd0; lutr[7] = 16'd4;
    repeat (3) @(negedge clk);
    chk("reset_busy", o_busy, 0);
    chk("reset_done", o_done, 0);
    chk("reset_rd", o_bin_rd, 0);
    chk("reset_bin_addr", o_bin_addr, 0);
    chk("reset_mag_en", o_mag_en, 0);
    chk("reset_ix_real", o_mag_addr_real, 0);
    chk("reset_we", o_out_we, 0);
    chk("reset_out_data", o_out_data, 0);
    chk("reset_peak", o_peak_mag, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    load_main();
    run_frame(0, 9, 1, 1'b0);
    load_sat();
    run_frame(0, 865, 7, 1'b1);
    load_main();
    run_frame(1, 0, 0, 1'b1);
    run_frame(0, 9, 1, 1'b1);
    run_frame(2, 0, 0, 1'b1);
    run_frame(0, 9, 1, 1'b0);
    repeat (4) @(negedge clk);

    chk("left_rd", q_rd.size(), 0);
    chk("left_ix", q_ix.size(), 0);
    chk("left_wr", q_wr.size(), 0);
    chk("left_done", q_dn.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
